// File: rtl/approx_mon_pkg.sv
// Purpose : shared types, widths and width helpers for the approximate-multiplier error monitor.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: mon_state_t FSM encoding, PROD_W/ERR_W, and sum/bias/count width helpers.
package approx_mon_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DRAIN  = 2'd1,
      REPORT = 2'd2
   } mon_state_t;

   localparam int PROD_W = 16;   // unsigned 8x8 product
   localparam int ERR_W  = 17;   // signed z - x*y

   // The sum of 2^win_log2 values, each below 2^PROD_W, fits in PROD_W+win_log2 bits.
   function automatic int sum_w(input int win_log2);
      return PROD_W + win_log2;
   endfunction

   // The signed sum of 2^win_log2 ERR_W-bit values needs win_log2 extra bits.
   function automatic int bias_w(input int win_log2);
      return ERR_W + win_log2;
   endfunction

   // The counter has to reach 2^win_log2 itself, so it needs one extra bit.
   function automatic int cnt_w(input int win_log2);
      return win_log2 + 1;
   endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Purpose : combinational error of one approximate product against the exact x*y.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller's stage register does the qualification.
// Ports   : in_x, in_y (8b operands), in_z (16b approximate product) -> err (17b signed), abs_err (16b).
module approx_err_calc
   import approx_mon_pkg::*;
(
   input  logic [7:0]              in_x,
   input  logic [7:0]              in_y,
   input  logic [PROD_W-1:0]       in_z,
   output logic signed [ERR_W-1:0] err,
   output logic [PROD_W-1:0]       abs_err
);

   logic [PROD_W-1:0] exact;

   always_comb begin
      exact   = {8'd0, in_x} * {8'd0, in_y};
      err     = $signed({1'b0, in_z}) - $signed({1'b0, exact});
      // |err| is at most 65535 because both operands lie in 0..65535, so 16 bits hold it.
      abs_err = err[ERR_W-1] ? PROD_W'(-err) : PROD_W'(err);
   end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Purpose : accumulates |err|, max |err|, nonzero-error count (and signed bias) over 2^WIN_LOG2 samples.
// Latency : the report is valid 2 edges after the last sample of a window is accepted.
// Backpr. : in_ready drops from the last accept until the report handshake; the report holds while out_ready=0.
// Ports   : clk, rst_n (async low), clr (sync abort); in_valid/in_ready/in_x/in_y/in_z sample stream;
//           out_valid/out_ready + out_sum_abs/out_max_abs/out_nz_cnt report; out_bias only with ERR_MON_BIAS_EN.
module approx_mul_err_monitor
   import approx_mon_pkg::*;
#(
   parameter int WIN_LOG2 = 8
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [7:0]                    in_x,
   input  logic [7:0]                    in_y,
   input  logic [PROD_W-1:0]             in_z,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [sum_w(WIN_LOG2)-1:0]    out_sum_abs,
   output logic [PROD_W-1:0]             out_max_abs,
   output logic [cnt_w(WIN_LOG2)-1:0]    out_nz_cnt
`ifdef ERR_MON_BIAS_EN
   ,
   output logic signed [bias_w(WIN_LOG2)-1:0] out_bias
`endif
);

   localparam int SUM_W = sum_w(WIN_LOG2);
   localparam int CNT_W = cnt_w(WIN_LOG2);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << WIN_LOG2) - 1);

   mon_state_t state, state_nxt;
   logic       accept;
   logic       rdy_en;        // holds in_ready low until the first edge after reset release
   logic       report_done;

   logic [CNT_W-1:0]        cnt;
   logic                    v1;
   logic signed [ERR_W-1:0] err1;
   logic [PROD_W-1:0]       abs1;
   logic signed [ERR_W-1:0] err_c;
   logic [PROD_W-1:0]       abs_c;

   logic [SUM_W-1:0]  sum_acc;
   logic [PROD_W-1:0] max_acc;
   logic [CNT_W-1:0]  nz_acc;

   approx_err_calc u_calc (
      .in_x    (in_x),
      .in_y    (in_y),
      .in_z    (in_z),
      .err     (err_c),
      .abs_err (abs_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ACCUM;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      accept      = 1'b0;
      report_done = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = rdy_en & ~clr;
            accept   = in_valid & in_ready;
            if (accept && cnt == LAST_IDX) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!v1) state_nxt = REPORT;
         end
         REPORT: begin
            out_valid   = 1'b1;
            report_done = out_ready;
            if (out_ready) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
      if (clr) state_nxt = ACCUM;
   end

   // Stage 1: capture the error of each accepted sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         err1 <= '0;
         abs1 <= '0;
      end else if (clr) begin
         v1 <= 1'b0;
      end else begin
         v1 <= accept;
         if (accept) begin
            err1 <= err_c;
            abs1 <= abs_c;
         end
      end
   end

   // Stage 2: window accumulators. v1 is never set in REPORT, so the clear never races an update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         sum_acc <= '0;
         max_acc <= '0;
         nz_acc  <= '0;
      end else if (clr || report_done) begin
         cnt     <= '0;
         sum_acc <= '0;
         max_acc <= '0;
         nz_acc  <= '0;
      end else begin
         if (accept) cnt <= cnt + CNT_W'(1);
         if (v1) begin
            sum_acc <= sum_acc + SUM_W'(abs1);
            if (abs1 > max_acc) max_acc <= abs1;
            if (err1 != '0) nz_acc <= nz_acc + CNT_W'(1);
         end
      end
   end

`ifdef ERR_MON_BIAS_EN
   localparam int BIAS_W = bias_w(WIN_LOG2);
   logic signed [BIAS_W-1:0] bias_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_acc <= '0;
      end else if (clr || report_done) begin
         bias_acc <= '0;
      end else if (v1) begin
         bias_acc <= bias_acc + {{WIN_LOG2{err1[ERR_W-1]}}, err1};
      end
   end

   assign out_bias = bias_acc;
`endif

   assign out_sum_abs = sum_acc;
   assign out_max_abs = max_acc;
   assign out_nz_cnt  = nz_acc;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Purpose : directed self-checking bench for approx_mul_err_monitor at WIN_LOG2 = 2.
// Latency : n/a.
// Backpr. : exercises report backpressure, clr and asynchronous reset.
module tb_approx_mul_err_monitor;

   localparam int WL = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_x = '0;
   logic [7:0]  in_y = '0;
   logic [15:0] in_z = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [17:0] out_sum_abs;
   logic [15:0] out_max_abs;
   logic [2:0]  out_nz_cnt;
`ifdef ERR_MON_BIAS_EN
   logic signed [18:0] out_bias;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  wx [4];
   logic [7:0]  wy [4];
   logic [15:0] wz [4];

   always #5 clk = ~clk;

   approx_mul_err_monitor #(.WIN_LOG2(WL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_z        (in_z),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum_abs (out_sum_abs),
      .out_max_abs (out_max_abs),
      .out_nz_cnt  (out_nz_cnt)
`ifdef ERR_MON_BIAS_EN
      ,
      .out_bias    (out_bias)
`endif
   );

   // Stimulus helpers: called #1 after a rising edge, return there. They do not compare.
   task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [15:0] z,
                       output logic rdy);
      in_valid = 1'b1; in_x = x; in_y = y; in_z = z;
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Pushes the window in wx/wy/wz back-to-back, then waits (bounded) for out_valid.
   // Returns at the falling edge where out_valid was seen (lat = falling edges waited, 0 = timeout).
   task automatic run_window(output int n_rdy, output int lat, output logic rdy_in_drain);
      logic r;
      n_rdy = 0; lat = 0; rdy_in_drain = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(wx[i], wy[i], wz[i], r);
         if (r === 1'b1) n_rdy++;
      end
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (in_ready !== 1'b0) rdy_in_drain = 1'b1;
         if (out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_err_window;
      for (int i = 0; i < 4; i++) begin
         wx[i] = 8'd3; wy[i] = 8'd255; wz[i] = 16'd384;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_sum_abs !== 18'd0 || out_max_abs !== 16'd0 || out_nz_cnt !== 3'd0) begin
         n_err++; $display("FAIL reset_report: got sum=%0d max=%0d nz=%0d want 0/0/0", out_sum_abs, out_max_abs, out_nz_cnt);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_full_error_window;
      int nr, lat; logic rd;
      load_err_window();
      run_window(nr, lat, rd);
      n_cmp++; if (nr !== 4) begin n_err++; $display("FAIL err_win_accepts: got %0d want 4", nr); end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL err_win_latency: got %0d edges want 2", lat - 1); end
      n_cmp++; if (rd !== 1'b0) begin n_err++; $display("FAIL err_win_drain_ready: got %b want 0", rd); end
      n_cmp++; if (out_sum_abs !== 18'd1524) begin n_err++; $display("FAIL err_win_sum: got %0d want 1524", out_sum_abs); end
      n_cmp++; if (out_max_abs !== 16'd381) begin n_err++; $display("FAIL err_win_max: got %0d want 381", out_max_abs); end
      n_cmp++; if (out_nz_cnt !== 3'd4) begin n_err++; $display("FAIL err_win_nz: got %0d want 4", out_nz_cnt); end
`ifdef ERR_MON_BIAS_EN
      n_cmp++; if (out_bias !== -19'sd1524) begin n_err++; $display("FAIL err_win_bias: got %0d want -1524", out_bias); end
`endif
      consume();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL err_win_after_hs: got valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      n_cmp++; if (out_sum_abs !== 18'd0 || out_max_abs !== 16'd0 || out_nz_cnt !== 3'd0) begin
         n_err++; $display("FAIL err_win_cleared: got sum=%0d max=%0d nz=%0d want 0/0/0", out_sum_abs, out_max_abs, out_nz_cnt);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_exact_window;
      int nr, lat; logic rd;
      for (int i = 0; i < 4; i++) begin
         wx[i] = 8'd200; wy[i] = 8'd100; wz[i] = 16'd20000;
      end
      run_window(nr, lat, rd);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL exact_latency: got %0d edges want 2", lat - 1); end
      n_cmp++; if (out_sum_abs !== 18'd0 || out_max_abs !== 16'd0 || out_nz_cnt !== 3'd0) begin
         n_err++; $display("FAIL exact_report: got sum=%0d max=%0d nz=%0d want 0/0/0", out_sum_abs, out_max_abs, out_nz_cnt);
      end
`ifdef ERR_MON_BIAS_EN
      n_cmp++; if (out_bias !== 19'sd0) begin n_err++; $display("FAIL exact_bias: got %0d want 0", out_bias); end
`endif
      consume();
      @(posedge clk); #1;
   endtask

   task automatic load_mixed_window;
      wx[0] = 8'd3; wy[0] = 8'd255; wz[0] = 16'd384;
      wx[1] = 8'd1; wy[1] = 8'd1;   wz[1] = 16'd1;
      wx[2] = 8'd2; wy[2] = 8'd2;   wz[2] = 16'd4;
      wx[3] = 8'd0; wy[3] = 8'd9;   wz[3] = 16'd0;
   endtask

   task automatic test_mixed_window;
      int nr, lat; logic rd;
      load_mixed_window();
      run_window(nr, lat, rd);
      n_cmp++; if (nr !== 4 || lat !== 3) begin n_err++; $display("FAIL mixed_flow: got accepts=%0d lat=%0d want 4/3", nr, lat); end
      n_cmp++; if (out_sum_abs !== 18'd381 || out_max_abs !== 16'd381 || out_nz_cnt !== 3'd1) begin
         n_err++; $display("FAIL mixed_report: got sum=%0d max=%0d nz=%0d want 381/381/1", out_sum_abs, out_max_abs, out_nz_cnt);
      end
`ifdef ERR_MON_BIAS_EN
      n_cmp++; if (out_bias !== -19'sd381) begin n_err++; $display("FAIL mixed_bias: got %0d want -381", out_bias); end
`endif
      consume();
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      int nr, lat; logic rd;
      int bad_hold;
      load_err_window();
      run_window(nr, lat, rd);
      bad_hold = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum_abs !== 18'd1524 ||
             out_max_abs !== 16'd381 || out_nz_cnt !== 3'd4) bad_hold++;
         @(negedge clk);
      end
      n_cmp++; if (bad_hold !== 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad_hold); end
      n_cmp++; if (out_valid !== 1'b1 || out_sum_abs !== 18'd1524) begin
         n_err++; $display("FAIL bp_before_hs: got valid=%b sum=%0d want 1/1524", out_valid, out_sum_abs);
      end
      consume();
      n_cmp++; if (in_ready !== 1'b1 || out_sum_abs !== 18'd0 || out_nz_cnt !== 3'd0) begin
         n_err++; $display("FAIL bp_after_hs: got ready=%b sum=%0d nz=%0d want 1/0/0", in_ready, out_sum_abs, out_nz_cnt);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_clr;
      int nr, lat; logic rd, r;
      push(8'd3, 8'd255, 16'd384, r);
      push(8'd3, 8'd255, 16'd384, r);
      clr = 1'b1; in_valid = 1'b1; in_x = 8'd3; in_y = 8'd255; in_z = 16'd384;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clr_in_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_sum_abs !== 18'd0 || out_nz_cnt !== 3'd0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL clr_cleared: got sum=%0d nz=%0d valid=%b want 0/0/0", out_sum_abs, out_nz_cnt, out_valid);
      end
      @(posedge clk); #1;
      load_mixed_window();
      run_window(nr, lat, rd);
      n_cmp++; if (nr !== 4 || lat !== 3) begin n_err++; $display("FAIL clr_next_flow: got accepts=%0d lat=%0d want 4/3", nr, lat); end
      n_cmp++; if (out_sum_abs !== 18'd381 || out_max_abs !== 16'd381 || out_nz_cnt !== 3'd1) begin
         n_err++; $display("FAIL clr_next_report: got sum=%0d max=%0d nz=%0d want 381/381/1", out_sum_abs, out_max_abs, out_nz_cnt);
      end
      consume();
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_window;
      int nr, lat; logic rd, r;
      push(8'd3, 8'd255, 16'd384, r);
      push(8'd3, 8'd255, 16'd384, r);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_flags: got valid=%b ready=%b want 0/0", out_valid, in_ready);
      end
      n_cmp++; if (out_sum_abs !== 18'd0 || out_max_abs !== 16'd0 || out_nz_cnt !== 3'd0) begin
         n_err++; $display("FAIL rst_mid_report: got sum=%0d max=%0d nz=%0d want 0/0/0", out_sum_abs, out_max_abs, out_nz_cnt);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      load_err_window();
      run_window(nr, lat, rd);
      n_cmp++; if (nr !== 4 || lat !== 3) begin n_err++; $display("FAIL rst_next_flow: got accepts=%0d lat=%0d want 4/3", nr, lat); end
      n_cmp++; if (out_sum_abs !== 18'd1524 || out_max_abs !== 16'd381 || out_nz_cnt !== 3'd4) begin
         n_err++; $display("FAIL rst_next_report: got sum=%0d max=%0d nz=%0d want 1524/381/4", out_sum_abs, out_max_abs, out_nz_cnt);
      end
      consume();
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_full_error_window();
      test_exact_window();
      test_mixed_window();
      test_backpressure();
      test_clr();
      test_reset_mid_window();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000 want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
